// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: control, vector and response bundle between a BIST driver and gate_bist_ctrl.
interface gate_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [13:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  signature;
    logic [15:0] pat_cnt;
    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, signature, pat_cnt
    );
    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR vector source and MISR response compactor around a 14-in/10-out gate model.
module gate_bist_ctrl #(
    parameter int          NUM_PAT   = 256,
    parameter int          SETTLE    = 2,
    parameter logic [13:0] LFSR_SEED = 14'h0001,
    parameter logic [9:0]  MISR_SEED = 10'h000,
    parameter logic [9:0]  GOLDEN    = 10'h000
) (
    input logic              clk,
    input logic              rst_n,
    gate_bist_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] PAT_LAST    = 16'(NUM_PAT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_settle;
    logic [13:0] r_lfsr;
    logic [9:0]  r_misr;
    logic [15:0] r_cnt;
    logic        r_done;
    logic        r_pass;
    logic [13:0] w_lfsr_nxt;
    logic [9:0]  w_misr_nxt;

    assign w_lfsr_nxt = {r_lfsr[12:0], r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[11] ^ r_lfsr[1]};
    // Shift with feedback into bit 0, then fold the whole response word in.
    assign w_misr_nxt = {r_misr[8:0], r_misr[9] ^ r_misr[6]} ^ bus.dut_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
            r_lfsr   <= '0;
            r_misr   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (bus.start) begin
                    r_state  <= S_APPLY;
                    r_lfsr   <= LFSR_SEED;
                    r_misr   <= MISR_SEED;
                    r_cnt    <= '0;
                    r_settle <= '0;
                    r_done   <= 1'b0;
                    r_pass   <= 1'b0;
                end
                S_APPLY: begin
                    r_state  <= (r_settle == SETTLE_LAST) ? S_CAPTURE : S_APPLY;
                    r_settle <= (r_settle == SETTLE_LAST) ? '0 : r_settle + 16'd1;
                end
                S_CAPTURE: begin
                    r_misr  <= w_misr_nxt;
                    r_lfsr  <= w_lfsr_nxt;
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= (r_cnt == PAT_LAST) ? S_CHECK : S_APPLY;
                end
                S_CHECK: begin
                    r_pass  <= (r_misr == GOLDEN);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_in    = r_lfsr;
    assign bus.signature = r_misr;
    assign bus.pat_cnt   = r_cnt;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.busy      = (r_state == S_APPLY) || (r_state == S_CAPTURE) || (r_state == S_CHECK);
endmodule
